pixel_write_sink: RTL

PIXEL_WRITE_SINK -- requirements
Module: pixel_write_sink

---
 rtl/pixel_write_sink.sv | 108 ++++++++++
 1 files changed

// File: rtl/pixel_write_sink.sv
// Buffers in-range pixel plots in order and drains them to a single-port framebuffer.
// One cycle from accepted plot to mem_we. A full FIFO or an off-screen plot drops the pixel and bumps drop_count.
module pixel_write_sink #(
    parameter int DEPTH    = 4,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        plot,
    input  logic [7:0]  x,
    input  logic [6:0]  y,
    input  logic [2:0]  colour,
    output logic        ready,
    output logic        mem_we,
    output logic [14:0] mem_addr,
    output logic [2:0]  mem_data,
    input  logic        mem_ack,
    output logic        busy,
    output logic [7:0]  drop_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [8:0]  X_LIM = 9'(SCREEN_W);
    localparam logic [7:0]  Y_LIM = 8'(SCREEN_H);
    localparam logic [14:0] ROW_W = 15'(SCREEN_W);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [14:0]   addr_q [DEPTH];
    logic [14:0]   addr_d [DEPTH];
    logic [2:0]    col_q  [DEPTH];
    logic [2:0]    col_d  [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    drop_count_q, drop_count_d;

    logic          in_range;
    logic          push;
    logic          pop;
    logic          drop;
    logic [14:0]   enq_addr;

    // ready looks only at registered occupancy, so a same-edge pop never frees a slot early.
    assign ready      = (count_q < FULL);
    assign busy       = (count_q != '0);
    assign mem_we     = busy;
    assign mem_addr   = addr_q[rd_ptr_q];
    assign mem_data   = col_q[rd_ptr_q];
    assign drop_count = drop_count_q;

    assign in_range = ({1'b0, x} < X_LIM) && ({1'b0, y} < Y_LIM);
    assign push     = plot && ready && in_range;
    assign drop     = plot && !push;
    assign pop      = busy && mem_ack;
    assign enq_addr = (15'(y) * ROW_W) + 15'(x);

    always_comb begin
        addr_d       = addr_q;
        col_d        = col_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        drop_count_d = drop_count_q;

        if (push) begin
            addr_d[wr_ptr_q] = enq_addr;
            col_d[wr_ptr_q]  = colour;
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (drop && (drop_count_q != 8'hFF)) begin
            drop_count_d = drop_count_q + 8'd1;
        end
    end

    // Whole storage is cleared so the head reads 0, never X, after reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                col_q[i]  <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            drop_count_q <= '0;
        end else begin
            addr_q       <= addr_d;
            col_q        <= col_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            drop_count_q <= drop_count_d;
        end
    end

endmodule
